// File: rtl/fast_pixel_engine.sv
// FAST-9 segment-test engine: fetches a 16-pixel Bresenham circle per column,
// classifies bright/dark against the centre and scans for a contiguous arc.
module fast_pixel_engine #(
  parameter int WIDTH   = 400,
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     fast_start,
  input  logic [PIX_W-1:0]         threshold,
  output logic                     rd_en,
  output logic [2:0]               rd_row,
  output logic [$clog2(WIDTH)-1:0] rd_col,
  input  logic [PIX_W-1:0]         rd_data,
  output logic                     fast_done_flag,
  output logic                     is_corner,
  output logic [$clog2(WIDTH)-1:0] corner_x,
  output logic                     row_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [4:0] ARC = 5'(ARC_LEN);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [4:0]       cnt;
  logic [PIX_W-1:0] thr;
  logic [PIX_W-1:0] centre;
  logic [15:0]      bright;
  logic [15:0]      dark;
  logic [4:0]       b_run;
  logic [4:0]       d_run;
  logic             corner;

  // {dx, dy} as 3-bit two's complement, circle order k = 0..15
  function automatic logic [5:0] offs(input logic [3:0] k);
    unique case (k)
      4'd0:    offs = {3'b000, 3'b101};
      4'd1:    offs = {3'b001, 3'b101};
      4'd2:    offs = {3'b010, 3'b110};
      4'd3:    offs = {3'b011, 3'b111};
      4'd4:    offs = {3'b011, 3'b000};
      4'd5:    offs = {3'b011, 3'b001};
      4'd6:    offs = {3'b010, 3'b010};
      4'd7:    offs = {3'b001, 3'b011};
      4'd8:    offs = {3'b000, 3'b011};
      4'd9:    offs = {3'b111, 3'b011};
      4'd10:   offs = {3'b110, 3'b010};
      4'd11:   offs = {3'b101, 3'b001};
      4'd12:   offs = {3'b101, 3'b000};
      4'd13:   offs = {3'b101, 3'b111};
      4'd14:   offs = {3'b110, 3'b110};
      default: offs = {3'b111, 3'b101};
    endcase
  endfunction

  logic [5:0]    ofs;
  logic [2:0]    dx;
  logic [2:0]    dy;
  logic [CW-1:0] dxe;
  logic [3:0]    kcap;
  logic [3:0]    ek;
  logic [PIX_W:0] p_ext;
  logic [PIX_W:0] c_ext;
  logic [PIX_W:0] t_ext;
  logic          is_bright;
  logic          is_dark;
  logic [4:0]    b_nxt;
  logic [4:0]    d_nxt;
  logic          hit;
  logic          last;
  logic          border;

  assign ofs  = offs(cnt[3:0]);
  assign dx   = ofs[5:3];
  assign dy   = ofs[2:0];
  assign dxe  = {{(CW-3){dx[2]}}, dx};
  assign kcap = cnt[3:0] - 4'd2;
  assign ek   = cnt[3:0];

  assign p_ext = {1'b0, rd_data};
  assign c_ext = {1'b0, centre};
  assign t_ext = {1'b0, thr};
  assign is_bright = p_ext > (c_ext + t_ext);
  assign is_dark   = (p_ext + t_ext) < c_ext;

  assign b_nxt = !bright[ek] ? 5'd0 :
                 (b_run == 5'd31) ? b_run : b_run + 5'd1;
  assign d_nxt = !dark[ek] ? 5'd0 :
                 (d_run == 5'd31) ? d_run : d_run + 5'd1;
  assign hit   = (b_nxt >= ARC) || (d_nxt >= ARC);

  assign last   = col == CW'(WIDTH-1);
  assign border = (col < CW'(3)) || (col > CW'(WIDTH-4));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      col            <= '0;
      cnt            <= '0;
      thr            <= '0;
      centre         <= '0;
      bright         <= '0;
      dark           <= '0;
      b_run          <= '0;
      d_run          <= '0;
      corner         <= 1'b0;
      rd_en          <= 1'b0;
      rd_row         <= '0;
      rd_col         <= '0;
      fast_done_flag <= 1'b0;
      is_corner      <= 1'b0;
      corner_x       <= '0;
      row_done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fast_start) begin
            thr    <= threshold;
            cnt    <= '0;
            bright <= '0;
            dark   <= '0;
            if (border) begin
              state          <= DONE;
              fast_done_flag <= 1'b1;
              is_corner      <= 1'b0;
              corner_x       <= col;
              row_done       <= last;
            end else begin
              state  <= FETCH;
              rd_en  <= 1'b1;
              rd_row <= 3'd3;
              rd_col <= col;
            end
          end
        end
        FETCH: begin
          cnt <= cnt + 5'd1;
          // cnt here also names the next circle read to issue
          if (cnt <= 5'd15) begin
            rd_en  <= 1'b1;
            rd_row <= 3'd3 + dy;
            rd_col <= col + dxe;
          end else begin
            rd_en  <= 1'b0;
            rd_row <= '0;
            rd_col <= '0;
          end
          if (cnt == 5'd1) begin
            centre <= rd_data;
          end else if (cnt >= 5'd2) begin
            bright[kcap] <= is_bright;
            dark[kcap]   <= is_dark;
          end
          if (cnt == 5'd17) begin
            state  <= EVAL;
            cnt    <= '0;
            b_run  <= '0;
            d_run  <= '0;
            corner <= 1'b0;
          end
        end
        EVAL: begin
          cnt    <= cnt + 5'd1;
          b_run  <= b_nxt;
          d_run  <= d_nxt;
          corner <= corner | hit;
          if (cnt == 5'd23) begin
            state          <= DONE;
            fast_done_flag <= 1'b1;
            is_corner      <= corner | hit;
            corner_x       <= col;
            row_done       <= last;
          end
        end
        DONE: begin
          fast_done_flag <= 1'b0;
          is_corner      <= 1'b0;
          corner_x       <= '0;
          row_done       <= 1'b0;
          col            <= last ? '0 : col + CW'(1);
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_pixel_engine.sv
// Bench for fast_pixel_engine: line-buffer model, directed and random
// pixels checked against a segment-test reference model.
module tb_fast_pixel_engine;

  localparam int WIDTH = 400;
  localparam int ARCL  = 9;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       fast_start = 1'b0;
  logic [7:0] threshold = '0;
  logic       rd_en;
  logic [2:0] rd_row;
  logic [8:0] rd_col;
  logic [7:0] rd_data = '0;
  logic       fast_done_flag;
  logic       is_corner;
  logic [8:0] corner_x;
  logic       row_done;

  fast_pixel_engine #(.WIDTH(WIDTH), .PIX_W(8), .ARC_LEN(ARCL)) dut (
    .clk(clk), .n_rst(n_rst), .fast_start(fast_start),
    .threshold(threshold), .rd_en(rd_en), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data),
    .fast_done_flag(fast_done_flag), .is_corner(is_corner),
    .corner_x(corner_x), .row_done(row_done)
  );

  always #5 clk = ~clk;

  logic [7:0]  img [7][WIDTH];
  logic [11:0] rq [$];
  int addr_err = 0;
  int done_cnt = 0;
  int checks = 0;
  int passes = 0;
  int ecol = 0;
  int pat [16];

  int dxs [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dys [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  always @(posedge clk) begin
    if (fast_done_flag) done_cnt++;
    if (rd_en) begin
      rq.push_back({rd_row, rd_col});
      if (rd_row < 3'd7 && rd_col < 9'(WIDTH))
        rd_data <= img[rd_row][rd_col];
      else
        rd_data <= '0;
    end else begin
      rd_data <= '0;
      if (rd_row != 3'd0 || rd_col != 9'd0) addr_err++;
    end
  end

  function automatic bit model(input int col, input int t);
    int c, p;
    bit b [16];
    bit d [16];
    bit rb, rdk;
    if (col < 3 || col > WIDTH - 4) return 1'b0;
    c = int'(img[3][col]);
    for (int k = 0; k < 16; k++) begin
      p = int'(img[3 + dys[k]][col + dxs[k]]);
      b[k] = p > c + t;
      d[k] = p + t < c;
    end
    for (int s = 0; s < 16; s++) begin
      rb = 1'b1;
      rdk = 1'b1;
      for (int j = 0; j < ARCL; j++) begin
        rb  = rb & b[(s + j) % 16];
        rdk = rdk & d[(s + j) % 16];
      end
      if (rb || rdk) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic fill(input int v);
    for (int r = 0; r < 7; r++)
      for (int x = 0; x < WIDTH; x++) img[r][x] = 8'(v);
  endtask

  task automatic set_pix(input int col, input int c);
    int x;
    if (col >= 0 && col < WIDTH) img[3][col] = 8'(c);
    for (int k = 0; k < 16; k++) begin
      x = col + dxs[k];
      if (x >= 0 && x < WIDTH) img[3 + dys[k]][x] = 8'(pat[k]);
    end
  endtask

  task automatic do_pixel(input int t, output bit dn, output int lat,
                          output bit cor, output int x, output bit rdn);
    rq.delete();
    threshold = 8'(t);
    fast_start = 1'b1;
    dn = 0; lat = 0; cor = 0; x = -1; rdn = 0;
    for (int i = 0; i < 100 && !dn; i++) begin
      @(posedge clk); #1;
      lat++;
      if (fast_done_flag) begin
        dn = 1; cor = is_corner; x = int'(corner_x); rdn = row_done;
        fast_start = 1'b0;
      end
    end
    fast_start = 1'b0;
    ecol = (ecol + 1) % WIDTH;
    @(posedge clk); #1;
  endtask

  task automatic advance_to(input int target);
    bit dn, cor, rdn;
    int lat, x;
    while (ecol != target) do_pixel(20, dn, lat, cor, x, rdn);
  endtask

  task automatic test_reset;
    checks++;
    if ({rd_en, rd_row, rd_col} !== 13'd0)
      $display("FAIL reset_rd: got %b want 0", {rd_en, rd_row, rd_col});
    else passes++;
    checks++;
    if ({fast_done_flag, is_corner, corner_x, row_done} !== 12'd0)
      $display("FAIL reset_out: got %b want 0",
               {fast_done_flag, is_corner, corner_x, row_done});
    else passes++;
  endtask

  task automatic test_flat_row;
    int pulses = 0, xerr = 0, cors = 0, rds = 0, rdx = -1;
    fill(50);
    threshold = 8'd20;
    fast_start = 1'b1;
    for (int i = 0; i < 400 * 44 + 200 && pulses < 400; i++) begin
      @(posedge clk); #1;
      if (fast_done_flag) begin
        if (int'(corner_x) != pulses) xerr++;
        if (is_corner) cors++;
        if (row_done) begin rds++; rdx = int'(corner_x); end
        pulses++;
        if (pulses == 400) fast_start = 1'b0;
      end
    end
    fast_start = 1'b0;
    @(posedge clk); #1;
    ecol = 0;
    checks++;
    if (pulses != 400) $display("FAIL flat_pulses: got %0d want 400", pulses);
    else passes++;
    checks++;
    if (xerr != 0) $display("FAIL flat_x_seq: got %0d errors want 0", xerr);
    else passes++;
    checks++;
    if (cors != 0) $display("FAIL flat_corner: got %0d want 0", cors);
    else passes++;
    checks++;
    if (rds != 1 || rdx != 399)
      $display("FAIL flat_row_done: got %0d at %0d want 1 at 399", rds, rdx);
    else passes++;
    checks++;
    if (addr_err != 0) $display("FAIL idle_addr: got %0d want 0", addr_err);
    else passes++;
  endtask

  task automatic test_border(input int c0);
    bit dn, cor, rdn;
    int lat, x;
    for (int c = c0; c < c0 + 3; c++) begin
      for (int k = 0; k < 16; k++) pat[k] = 250;
      set_pix(c, 10);
      do_pixel(5, dn, lat, cor, x, rdn);
      checks++;
      if (!dn || lat != 1) $display("FAIL border_lat c%0d: got %0d want 1", c, lat);
      else passes++;
      checks++;
      if (cor !== 1'b0 || x != c)
        $display("FAIL border_res c%0d: got %0d/x%0d want 0/x%0d", c, cor, x, c);
      else passes++;
      checks++;
      if (rq.size() != 0) $display("FAIL border_rd c%0d: got %0d want 0", c, rq.size());
      else passes++;
      checks++;
      if (rdn !== (c == WIDTH - 1))
        $display("FAIL border_row_done c%0d: got %0d want %0d", c, rdn, c == WIDTH - 1);
      else passes++;
    end
  endtask

  task automatic test_centre_corner;
    bit dn, cor, rdn;
    int lat, x, err;
    logic [11:0] ex;
    advance_to(10);
    for (int k = 0; k < 16; k++) pat[k] = 50;
    set_pix(10, 200);
    do_pixel(20, dn, lat, cor, x, rdn);
    checks++;
    if (!dn || lat != 43) $display("FAIL centre_lat: got %0d want 43", lat);
    else passes++;
    checks++;
    if (cor !== 1'b1 || x != 10)
      $display("FAIL centre_res: got %0d/x%0d want 1/x10", cor, x);
    else passes++;
    checks++;
    if (rq.size() != 17) $display("FAIL centre_nreads: got %0d want 17", rq.size());
    else passes++;
    err = 0;
    for (int i = 0; i < 17 && i < rq.size(); i++) begin
      ex = (i == 0) ? {3'd3, 9'd10}
                    : {3'(3 + dys[i-1]), 9'(10 + dxs[i-1])};
      if (rq[i] !== ex) err++;
    end
    checks++;
    if (err != 0) $display("FAIL centre_addr: got %0d bad want 0", err);
    else passes++;
  endtask

  task automatic test_arcs;
    bit dn, cor, rdn;
    int lat, x;
    advance_to(20);
    for (int k = 0; k < 16; k++) pat[k] = (k >= 12 || k <= 4) ? 121 : 100;
    set_pix(20, 100);
    do_pixel(20, dn, lat, cor, x, rdn);
    checks++;
    if (!dn || cor !== 1'b1) $display("FAIL arc9_wrap: got %0d want 1", cor);
    else passes++;
    for (int k = 0; k < 16; k++) pat[k] = (k >= 12 || k <= 3) ? 121 : 100;
    set_pix(21, 100);
    do_pixel(20, dn, lat, cor, x, rdn);
    checks++;
    if (!dn || cor !== 1'b0) $display("FAIL arc8_wrap: got %0d want 0", cor);
    else passes++;
    for (int k = 0; k < 16; k++) pat[k] = (k < 12) ? 120 : 100;
    set_pix(22, 100);
    do_pixel(20, dn, lat, cor, x, rdn);
    checks++;
    if (!dn || cor !== 1'b0) $display("FAIL equal_T: got %0d want 0", cor);
    else passes++;
    for (int k = 0; k < 16; k++) pat[k] = (k >= 3 && k <= 11) ? 79 : 100;
    set_pix(23, 100);
    do_pixel(20, dn, lat, cor, x, rdn);
    checks++;
    if (!dn || cor !== 1'b1 || x != 23)
      $display("FAIL dark_arc9: got %0d/x%0d want 1/x23", cor, x);
    else passes++;
  endtask

  task automatic test_random;
    bit dn, cor, rdn, exp_c;
    int lat, x, c, t, mode, s, len, col, v;
    for (int n = 0; n < 60; n++) begin
      col = ecol;
      c = $urandom_range(30, 225);
      t = $urandom_range(0, 30);
      mode = $urandom_range(0, 2);
      s = $urandom_range(0, 15);
      len = $urandom_range(7, 11);
      for (int k = 0; k < 16; k++) pat[k] = $urandom_range(0, 255);
      for (int j = 0; j < len && mode != 0; j++) begin
        if (mode == 1) begin
          v = c + t + $urandom_range(0, 20);
          pat[(s + j) % 16] = (v > 255) ? 255 : v;
        end else begin
          v = c - t - $urandom_range(0, 20);
          pat[(s + j) % 16] = (v < 0) ? 0 : v;
        end
      end
      set_pix(col, c);
      exp_c = model(col, t);
      do_pixel(t, dn, lat, cor, x, rdn);
      checks++;
      if (!dn || cor !== exp_c || x != col)
        $display("FAIL random c%0d: got %0d/x%0d want %0d/x%0d", col, cor, x, exp_c, col);
      else passes++;
    end
  endtask

  task automatic test_drop;
    int lat = 0, d0;
    bit dn = 0;
    bit exp_c, cor = 0;
    for (int k = 0; k < 16; k++) pat[k] = 240;
    set_pix(ecol, 60);
    exp_c = model(ecol, 10);
    d0 = done_cnt;
    rq.delete();
    threshold = 8'd10;
    fast_start = 1'b1;
    for (int i = 0; i < 100 && !dn; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 6) fast_start = 1'b0;
      if (fast_done_flag) begin dn = 1; cor = is_corner; end
    end
    ecol = (ecol + 1) % WIDTH;
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (!dn || lat != 43) $display("FAIL drop_lat: got %0d want 43", lat);
    else passes++;
    checks++;
    if (cor !== exp_c) $display("FAIL drop_res: got %0d want %0d", cor, exp_c);
    else passes++;
    checks++;
    if (done_cnt - d0 != 1 || rq.size() != 17)
      $display("FAIL drop_extra: got %0d pulses %0d reads want 1/17",
               done_cnt - d0, rq.size());
    else passes++;
  endtask

  task automatic test_reset_mid;
    bit dn, cor, rdn;
    int lat, x, d0;
    bit pre;
    threshold = 8'd10;
    fast_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pre = rd_en;
    n_rst = 1'b0;
    #1;
    checks++;
    if (pre !== 1'b1 || rd_en !== 1'b0)
      $display("FAIL reset_mid_rd: got %0d->%0d want 1->0", pre, rd_en);
    else passes++;
    fast_start = 1'b0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    ecol = 0;
    checks++;
    if (done_cnt != d0) $display("FAIL reset_mid_done: got %0d want 0", done_cnt - d0);
    else passes++;
    do_pixel(10, dn, lat, cor, x, rdn);
    checks++;
    if (!dn || x != 0 || lat != 1)
      $display("FAIL reset_mid_col: got x%0d lat%0d want x0 lat1", x, lat);
    else passes++;
  endtask

  initial begin
    fill(50);
    #1;
    test_reset;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_flat_row;
    test_border(0);
    test_centre_corner;
    test_arcs;
    test_random;
    advance_to(WIDTH - 3);
    test_border(WIDTH - 3);
    advance_to(3);
    test_drop;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fast_pixel_engine.md
# fast_pixel_engine

- Per-pixel FAST-9 segment-test engine and the responder to the FAST controller's `fast_start`/`fast_done_flag` handshake.
- While `fast_start` is high, it takes the next column of the current output row and fetches the centre pixel plus the 16-pixel radius-3 Bresenham circle from the 7-row Gaussian line buffer.
- It classifies each circle pixel as brighter or darker than the centre and searches, with wrap-around, for a contiguous arc of `ARC_LEN` pixels.
- It pulses `fast_done_flag` once per pixel and reports the corner result with the column index.

## Interface
- `WIDTH`, 400, pixels per image row.
- `PIX_W`, 8, pixel bit width.
- `ARC_LEN`, 9, minimum contiguous arc length for a corner (1..16).
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous active-low reset.
- `fast_start`  in  1  level request from the FAST controller; a pixel starts when high in IDLE.
- `threshold`  in  PIX_W  intensity threshold T, latched at pixel start.
- `rd_en`  out  1  line-buffer read strobe.
- `rd_row`  out  3  line-buffer row 0..6; row 3 is the centre row.
- `rd_col`  out  $clog2(WIDTH)  line-buffer column.
- `rd_data`  in  PIX_W  read data, valid exactly 1 cycle after `rd_en`.
- `fast_done_flag`  out  1  one-cycle pulse per completed pixel.
- `is_corner`  out  1  result, qualified by `fast_done_flag`.
- `corner_x`  out  $clog2(WIDTH)  column of the reported pixel, qualified by `fast_done_flag`.
- `row_done`  out  1  pulse coincident with `fast_done_flag` of column WIDTH-1.

## Operation
**States**
- IDLE: if `fast_start`, latch `threshold`.
  - Column `col` with col<3 or col>WIDTH-4 is a border pixel: go to DONE, `is_corner`=0.
  - Otherwise go to FETCH.
- FETCH: issue 17 reads on consecutive cycles, then 1 drain cycle (18 cycles).
  - Index 0 is the centre: row 3, col.
  - Indices 1..16 are circle positions k=0..15 with (dx,dy) in order: (0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3).
  - Circle reads use `rd_row`=3+dy and `rd_col`=col+dx.
- EVAL: fixed 24 cycles (16+ARC_LEN-1), no early exit.
  - Scan circular index k mod 16 for k=0..23.
  - Keep separate run counters for the bright and dark masks; each counter increments on a set bit and clears on a clear bit.
  - Counters are 5-bit saturating.
  - Corner is set if either counter reaches ARC_LEN.
- DONE: assert `fast_done_flag`, `is_corner`, `corner_x`=col, and `row_done` if col==WIDTH-1.
  - col then advances; it wraps from WIDTH-1 to 0. Return to IDLE.

**Classification (circle pixel p, centre c, all sums PIX_W+1 bits, no wrap)**
- bright if p > c+T; dark if p+T < c. Both comparisons are strict.
- Equality gives neither. T=0 is legal.

**Other rules**
- `fast_start` falling mid-pixel does not abort; the pixel completes and the engine then idles.
- The mandatory IDLE cycle after DONE lets the controller drop `fast_start` after its final count with no extra pixel started.
- `rd_en` is high only in the first 17 FETCH cycles. `rd_row`/`rd_col` are 0 when `rd_en` is low.

**Reset values**
- State IDLE, col 0.
- All outputs 0.
- Masks and run counters cleared.
- Reset in any state aborts the pixel with no done pulse; col restarts at 0.

## Timing
- `fast_start` is sampled high in IDLE at edge t.
- Interior pixel:
  - FETCH cycles t+1..t+18; `rd_en` high t+1..t+17.
  - EVAL cycles t+19..t+42.
  - `fast_done_flag` in cycle t+43; IDLE in t+44. 44 cycles per pixel.
- Border pixel: `fast_done_flag` in t+1, IDLE in t+2.
- Outputs are registered.
- `is_corner`, `corner_x` and `row_done` are valid only during the done pulse and are 0 otherwise.

## Test plan
- Flat image, all 50, T=20, `fast_start` held until 400 done pulses → 400 pulses, all `is_corner`=0; `row_done` once, with `corner_x`=399; col wraps to 0.
- Centre 200 on background 50 at col 10, T=20 → `is_corner`=1, `corner_x`=10; read sequence row/col matches the offset table; done exactly 43 cycles after start.
- Bright arc of 9 at indices 12..15,0..4 (wrap), p=c+21, T=20 → corner. Same test with an arc of 8 → no corner.
- Circle pixels exactly c+T on 12 positions → neither bright nor dark, no corner. Dark arc of 9 with p=c-21 → corner.
- Col 0..2 and 397..399 with a strong corner pattern → `is_corner`=0, done 1 cycle after start, no `rd_en`.
- Drop `fast_start` at t+5 → pixel still completes at t+43 and no new pixel starts. Assert `n_rst` at t+10 → `rd_en` low immediately, no done pulse, next pixel at col 0.
